// File: rtl/rib_timer_if.sv
// rib_timer_if: RIB slave-3 port as seen by the timer peripheral.
// The bus (master) drives address, write data and write strobe. The timer
// (slave) returns combinational read data and a level interrupt request.
// Handshake: there is no valid/ready pair. A write commits at every rising
// edge where we_i is high. data_o is valid in every cycle for the current
// addr_i. An idle bus presents addr_i=0 with we_i=0.
interface rib_timer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] data_i;
   logic              we_i;
   logic [DATA_W-1:0] data_o;
   logic              int_sig_o;

   modport master (
      output addr_i,
      output data_i,
      output we_i,
      input  data_o,
      input  int_sig_o
   );

   modport slave (
      input  addr_i,
      input  data_i,
      input  we_i,
      output data_o,
      output int_sig_o
   );
endinterface

// File: rtl/rib_timer.sv
// rib_timer: memory-mapped 32-bit compare timer for RIB slave 3.
// Register map, decoded from addr_i[3:2]:
//   0x0 CTRL  : EN(0) IE(1) PEND(2, W1C) ONESHOT(3) PSC(31:16, optional)
//   0x4 COUNT : current count
//   0x8 CMP   : compare value
//   0xC       : reads 0, writes ignored
// On each tick COUNT advances. When COUNT equals CMP, COUNT returns to 0 and
// PEND is set. int_sig_o = PEND & IE, taken from registers only.
// Optional feature macro: RIB_TIMER_PRESCALER_EN. When it is defined,
// CTRL[31:16] holds PSC and a tick fires once every PSC+1 enabled cycles.
module rib_timer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   rib_timer_if.slave  bus
);

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_COUNT = 2'd1;
   localparam logic [1:0] REG_CMP   = 2'd2;

   // Address decode. Only bits [3:2] select a register.
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [1:0]        reg_sel;
   logic              wr_ctrl;
   logic              wr_count;
   logic              wr_cmp;

   assign addr     = bus.addr_i;
   assign wdata    = bus.data_i;
   assign reg_sel  = addr[3:2];
   assign wr_ctrl  = bus.we_i && (reg_sel == REG_CTRL);
   assign wr_count = bus.we_i && (reg_sel == REG_COUNT);
   assign wr_cmp   = bus.we_i && (reg_sel == REG_CMP);

   // The undecoded address bits and some write-data bits are ignored on purpose.
   logic unused_bits;
   assign unused_bits = ^{addr[ADDR_W-1:4], addr[1:0], wdata};

   // Register state
   logic              en_q,      en_d;
   logic              ie_q,      ie_d;
   logic              pend_q,    pend_d;
   logic              oneshot_q, oneshot_d;
   logic [DATA_W-1:0] count_q,   count_d;
   logic [DATA_W-1:0] cmp_q,     cmp_d;

   logic              tick;
   logic              expire;

`ifdef RIB_TIMER_PRESCALER_EN
   logic [15:0]       psc_q,   psc_d;
   logic [15:0]       pscnt_q, pscnt_d;

   // A tick fires when the prescale counter reaches PSC. The period is PSC+1.
   always_comb begin
      tick = en_q && (pscnt_q == psc_q);
   end

   // The prescale counter runs only while enabled and restarts on any CTRL write.
   always_comb begin
      pscnt_d = pscnt_q + 16'd1;
      psc_d   = psc_q;
      if (!en_q || wr_ctrl || tick) begin
         pscnt_d = 16'd0;
      end
      if (wr_ctrl) begin
         psc_d = wdata[31:16];
      end
   end

   // Prescaler registers
   always_ff @(posedge clk) begin
      if (rst) begin
         psc_q   <= 16'd0;
         pscnt_q <= 16'd0;
      end else begin
         psc_q   <= psc_d;
         pscnt_q <= pscnt_d;
      end
   end
`else
   // Without a prescaler, every enabled cycle is a tick.
   always_comb begin
      tick = en_q;
   end
`endif

   // Expiry uses the CMP value that is already registered, so a CMP write
   // takes effect on the following cycle's compare.
   always_comb begin
      expire = tick && (count_q == cmp_q);
   end

   // Next-state logic. A software write has priority over the tick update,
   // except for PEND, where an expiry wins over a W1C clear.
   always_comb begin
      en_d      = en_q;
      ie_d      = ie_q;
      pend_d    = pend_q;
      oneshot_d = oneshot_q;
      count_d   = count_q;
      cmp_d     = cmp_q;

      if (tick) begin
         if (expire) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
      if (expire && oneshot_q) begin
         en_d = 1'b0;
      end

      if (wr_ctrl) begin
         en_d      = wdata[0];
         ie_d      = wdata[1];
         oneshot_d = wdata[3];
         if (wdata[2]) begin
            pend_d = 1'b0;
         end
      end
      if (expire) begin
         pend_d = 1'b1;
      end

      if (wr_count) begin
         count_d = wdata;
      end
      if (wr_cmp) begin
         cmp_d = wdata;
      end
   end

   // Timer registers. Reset clears all state.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q      <= 1'b0;
         ie_q      <= 1'b0;
         pend_q    <= 1'b0;
         oneshot_q <= 1'b0;
         count_q   <= '0;
         cmp_q     <= '0;
      end else begin
         en_q      <= en_d;
         ie_q      <= ie_d;
         pend_q    <= pend_d;
         oneshot_q <= oneshot_d;
         count_q   <= count_d;
         cmp_q     <= cmp_d;
      end
   end

   // Read mux. It is combinational from addr_i and has no side effects.
   logic [DATA_W-1:0] ctrl_rd;
   logic [DATA_W-1:0] rdata;

   always_comb begin
      ctrl_rd      = '0;
      ctrl_rd[0]   = en_q;
      ctrl_rd[1]   = ie_q;
      ctrl_rd[2]   = pend_q;
      ctrl_rd[3]   = oneshot_q;
`ifdef RIB_TIMER_PRESCALER_EN
      ctrl_rd[31:16] = psc_q;
`endif
      rdata = '0;
      case (reg_sel)
         REG_CTRL:  rdata = ctrl_rd;
         REG_COUNT: rdata = count_q;
         REG_CMP:   rdata = cmp_q;
         default:   rdata = '0;
      endcase
   end

   assign bus.data_o    = rdata;
   assign bus.int_sig_o = pend_q & ie_q;

endmodule

// File: tb/tb_rib_timer.sv
// tb_rib_timer: randomized and directed bench for rib_timer. A behavioural
// timer model predicts data_o and int_sig_o for every cycle. The driver
// queues those predictions, and a monitor compares them with the DUT.
// Build with +define+RIB_TIMER_PRESCALER_EN to cover the prescaler variant.
module tb_rib_timer;

   logic clk;
   logic rst;

   rib_timer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   rib_timer #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock and reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   logic mon_vld;
   logic [32:0] exp_q[$];

   // Reference model state, kept as the timer's architectural registers
   logic        m_en, m_ie, m_pend, m_oneshot;
   logic [31:0] m_count, m_cmp;
   logic [15:0] m_psc;
   int          m_wait;

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] ctrl;
      ctrl = {m_psc, 12'h000, m_oneshot, m_pend, m_ie, m_en};
      case (a[3:2])
         2'd0:    return ctrl;
         2'd1:    return m_count;
         2'd2:    return m_cmp;
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model across one rising edge.
   task automatic model_step(input logic r, input logic [31:0] a,
                             input logic [31:0] d, input logic w);
      logic tk, ex;
      logic wc;
      if (r) begin
         m_en = 0; m_ie = 0; m_pend = 0; m_oneshot = 0;
         m_count = 0; m_cmp = 0; m_psc = 0; m_wait = 0;
         return;
      end
      wc = w && (a[3:2] == 2'd0);
`ifdef RIB_TIMER_PRESCALER_EN
      // m_wait counts the enabled cycles since the last tick window began.
      tk = m_en && (m_wait == int'(m_psc));
      if (!m_en || wc || tk) m_wait = 0;
      else m_wait = m_wait + 1;
`else
      tk = m_en;
`endif
      ex = tk && (m_count == m_cmp);
      if (tk) m_count = ex ? 32'h0 : m_count + 32'h1;
      if (ex && m_oneshot) m_en = 0;
      if (wc) begin
         m_en = d[0];
         m_ie = d[1];
         m_oneshot = d[3];
         if (d[2]) m_pend = 0;
`ifdef RIB_TIMER_PRESCALER_EN
         m_psc = d[31:16];
`endif
      end
      if (ex) m_pend = 1;
      if (w && a[3:2] == 2'd1) m_count = d;
      if (w && a[3:2] == 2'd2) m_cmp = d;
   endtask

   // Driver: present one bus cycle, queue its predicted outputs, step the model
   task automatic cycle(input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic w);
      @(negedge clk);
      rst = r;
      bus.addr_i = a;
      bus.data_i = d;
      bus.we_i = w;
      exp_q.push_back({m_ie & m_pend, m_read(a)});
      mon_vld = 1'b1;
      model_step(r, a, d, w);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cycle(1'b0, a, d, 1'b1);
   endtask

   task automatic rd(input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, a, 32'h0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 32'h0, 32'h0, 1'b0);
   endtask

   // Monitor / scoreboard: compare the outputs once they have settled after the inputs change.
   always begin
      logic [32:0] e;
      @(negedge clk);
      #1;
      if (mon_vld) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            total++;
            if (bus.data_o !== e[31:0]) begin
               bad++;
               $display("FAIL rd_data addr=%h: got %h expected %h at %0t",
                        bus.addr_i, bus.data_o, e[31:0], $time);
            end
            total++;
            if (bus.int_sig_o !== e[32]) begin
               bad++;
               $display("FAIL int_sig: got %b expected %b at %0t",
                        bus.int_sig_o, e[32], $time);
            end
         end
      end
   end

   // Stimulus: directed scenarios first, then a random bus mix
   initial begin
      logic [31:0] a, d;
      logic [1:0]  sel;
      total = 0; bad = 0; mon_vld = 1'b0;
      rst = 1'b1;
      bus.addr_i = 32'h0; bus.data_i = 32'h0; bus.we_i = 1'b0;
      model_step(1'b1, 32'h0, 32'h0, 1'b0);

      // Reset, then read all four registers
      do_reset(2);
      rd(32'h0, 1); rd(32'h4, 1); rd(32'h8, 1); rd(32'hC, 1);

      // Periodic count, interrupt, then W1C while running
      wr(32'h8, 32'd3);
      wr(32'h0, 32'h3);
      rd(32'h4, 6);
      rd(32'h0, 1);
      wr(32'h0, 32'h7);
      rd(32'h0, 3);
      rd(32'h4, 2);

      // One-shot expiry
      do_reset(1);
      wr(32'h8, 32'd2);
      wr(32'h0, 32'h9);
      rd(32'h4, 4);
      rd(32'h0, 1);
      rd(32'h4, 10);

      // CMP=0 expires on every tick, so a W1C in an expiry cycle leaves PEND set
      do_reset(1);
      wr(32'h8, 32'd0);
      wr(32'h0, 32'h3);
      rd(32'h0, 2);
      wr(32'h0, 32'h7);
      rd(32'h0, 2);
      rd(32'h4, 2);

      // A COUNT write beats the tick, and COUNT wraps past the top
      do_reset(1);
      wr(32'h8, 32'd100);
      wr(32'h0, 32'h1);
      rd(32'h4, 3);
      wr(32'h4, 32'h50);
      rd(32'h4, 2);
      wr(32'h8, 32'd1);
      wr(32'h4, 32'hFFFF_FFFF);
      rd(32'h4, 4);
      rd(32'h0, 1);

      // PSC field: it is a prescaler when the macro is defined, otherwise ignored
      do_reset(1);
      wr(32'h8, 32'd1);
      wr(32'h0, 32'h0002_0001);
      rd(32'h0, 1);
      rd(32'h4, 12);
      rd(32'h0, 1);

      // Random mix with ignored address bits and an occasional reset
      for (int i = 0; i < 3000; i++) begin
         sel = 2'($urandom_range(0, 3));
         a = {4'h0, 24'($urandom()), sel, 2'($urandom_range(0, 3))};
         case (sel)
            2'd0: begin
               d = $urandom();
               d[15:4] = 12'($urandom());
               d[31:16] = 16'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 16'hFF00 : 16'h0);
               d[0] = ($urandom_range(0, 3) != 0);
            end
            2'd1: d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8))
                                                 : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2'd2: d = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 7));
            default: d = $urandom();
         endcase
         if ($urandom_range(0, 199) == 0) do_reset(1);
         else cycle(1'b0, a, d, ($urandom_range(0, 3) == 0));
      end

      rd(32'h0, 1);
      #2;
      mon_vld = 1'b0;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rib_timer.md
# rib_timer

Memory-mapped 32-bit timer peripheral on the RIB bus's slave 3 port, at the 0x3xxx_xxxx address region. It consumes the slave address, write data and write enable that the bus drives. It returns read data combinationally in the same cycle. It counts clock ticks against a compare value and raises a level interrupt on expiry.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous active-high
- addr_i  in  ADDR_W  slave address from bus; bits [31:28] arrive as 0; only [3:2] decoded, [1:0] ignored
- data_i  in  DATA_W  write data from bus
- we_i  in  1  write strobe; write commits at rising edge while high
- data_o  out  DATA_W  read data, combinational from addr_i and current registers
- int_sig_o  out  1  interrupt request, level, equals CTRL.PEND & CTRL.IE

## Operation
Register map (addr_i[3:2]):
- 0x0 CTRL:
  - bit0 EN, run
  - bit1 IE, interrupt enable
  - bit2 PEND, read; write 1 clears, write 0 no effect
  - bit3 ONESHOT, clear EN at expiry
  - [31:16] PSC, present only with macro
  - other bits read 0
- 0x4 COUNT: current count, read/write.
- 0x8 CMP: compare value, read/write.
- 0xC: reads 0, writes ignored.

Behaviour:
- Reads have no side effects. The bus drives address 0 with we_i=0 when slave 3 is not selected, so idle cycles cause harmless CTRL reads.
- Tick: one per cycle while EN=1. With the macro, the tick rate is set by the prescaler.
- On a tick:
  - COUNT==CMP: COUNT←0, PEND←1, and if ONESHOT then EN←0.
  - Otherwise: COUNT←COUNT+1, mod 2^32.
- COUNT>CMP (software-written): counts up, wraps 0xFFFF_FFFF→0, then reaches CMP normally.
- CMP=0: expires on every tick; COUNT stays 0; PEND re-sets every tick.
- EN=0: COUNT and PEND hold.

Priority and simultaneous events:
- Software write to COUNT beats a tick in the same cycle: the written value is loaded and no increment occurs that cycle.
- PEND set (expiry) beats a W1C clear in the same cycle: PEND stays 1, so no event is lost.
- CTRL write with EN=0 in an expiry cycle: EN=0 and the expiry still sets PEND.
- CMP write: the new value is used starting on the following cycle's compare.

## Timing
- Reset: CTRL, COUNT and CMP are 0; PSC and prescale counter are 0; int_sig_o is 0; data_o reflects the zeroed registers.
- Reset applied mid-count clears everything at that edge. There is no pending carry-over.
- Write latency: the register updates at the edge with we_i=1 and is visible on data_o the next cycle.
- Read latency: 0 cycles, combinational.
- Counting: with EN written at edge E, COUNT=1 after edge E+1. That is, the first tick is the cycle after EN is visible.
- Expiry at edge T sets PEND. int_sig_o rises in the cycle after T, because it is derived from registers and has no combinational path from the bus.
- int_sig_o deasserts the cycle after the W1C write, or after a write of IE=0.

## Configuration
Macro: RIB_TIMER_PRESCALER_EN.

Defined:
- CTRL[31:16] is PSC, read/write.
- A 16-bit prescale counter increments each cycle while EN=1.
- A tick fires when the prescale counter equals PSC; the counter then returns to 0. The tick period is PSC+1 cycles.
- The prescale counter clears when EN=0 and on any CTRL write.

Not defined:
- CTRL[31:16] reads 0 and writes are ignored.
- No prescale counter is implemented; tick = EN every cycle.

## Test plan
- Reset for 2 cycles, then read 0x0, 0x4, 0x8, 0xC → all 0x0000_0000; int_sig_o=0.
- Write CMP=3, then CTRL=0x3 → COUNT reads 1,2,3,0 on successive cycles. PEND=1 and int_sig_o=1 one cycle after the wrap. Writing CTRL=0x7 drops int_sig_o the next cycle while counting continues.
- CMP=2, CTRL=0x9 (ONESHOT) → after expiry, CTRL reads 0xC (EN=0, PEND=1) and COUNT holds 0 for 10 further cycles.
- CMP=0, CTRL=0x3, then write CTRL=0x7 in a cycle that is also an expiry → PEND still reads 1 and int_sig_o stays high.
- While running with CMP=100, write COUNT=0x50 → next read 0x50 with no increment that cycle, then 0x51. Write COUNT=0xFFFF_FFFF with CMP=1 → COUNT reads 0, then 1, then expiry.
- With macro: PSC=2, CMP=1, EN=1 → COUNT increments every 3 cycles and PEND sets 6 cycles after the first tick window. Without macro: write CTRL=0x0002_0001 → CTRL reads 0x1 and COUNT increments every cycle.
